// File: rtl/ghost_dist_map_gen.sv
// ghost_dist_map_gen: row-sweeping ghost distance-map generator (optional GHOST_MAP_WRAP_EN adds horizontal tunnel wrap)
module ghost_dist_map_gen #(
    parameter int MAP_W      = 40,
    parameter int MAP_H      = 30,
    parameter int X_W        = 6,
    parameter int Y_W        = 5,
    parameter int NUM_GHOSTS = 2,
    parameter int CELL_W     = 8,
    parameter int TILE_W     = 4,
    parameter int WALL_CODE  = 1
) (
    input  logic                         CLOCK_50,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         continuous,
    input  logic [X_W-1:0]               target_x,
    input  logic [Y_W-1:0]               target_y,
    input  logic [NUM_GHOSTS*X_W-1:0]    ghost_x,
    input  logic [NUM_GHOSTS*Y_W-1:0]    ghost_y,
    input  logic [NUM_GHOSTS*X_W-1:0]    prev_ghost_x,
    input  logic [NUM_GHOSTS*Y_W-1:0]    prev_ghost_y,
    output logic [Y_W-1:0]               map_rdaddr,
    input  logic [MAP_W*TILE_W-1:0]      map_word,
    output logic [Y_W-1:0]               dist_wraddr,
    output logic [MAP_W*CELL_W-1:0]      dist_wrdata,
    output logic                         dist_wren,
    output logic                         busy,
    output logic                         done,
    output logic                         ready
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CELL  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam int SW = (X_W > Y_W ? X_W : Y_W) + 2;
    localparam int CW2 = SW > CELL_W ? SW : CELL_W;
    localparam int BW = $clog2(MAP_W*CELL_W);
    localparam int TB = $clog2(MAP_W*TILE_W);
    localparam logic [CELL_W-1:0] C_WALL = '1;
    localparam logic [CELL_W-1:0] C_CUR  = C_WALL - CELL_W'(1);
    localparam logic [CELL_W-1:0] C_PRV  = C_WALL - CELL_W'(2);
    localparam logic [CELL_W-1:0] C_SAT  = C_WALL - CELL_W'(3);
    localparam logic [X_W-1:0] X_LAST = X_W'(MAP_W-1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(MAP_H-1);
`ifdef GHOST_MAP_WRAP_EN
    localparam logic [X_W:0] W_X = (X_W+1)'(MAP_W);
`endif

    logic [2:0]                  state_q, state_d;
    logic [Y_W-1:0]              row_q, row_d;
    logic [X_W-1:0]              x_q, x_d;
    logic [MAP_W*CELL_W-1:0]     buf_q, buf_d;
    logic [MAP_W*TILE_W-1:0]     word_q, word_d;
    logic [X_W-1:0]              tx_q, tx_d;
    logic [Y_W-1:0]              ty_q, ty_d;
    logic [NUM_GHOSTS*X_W-1:0]   gx_q, gx_d, px_q, px_d;
    logic [NUM_GHOSTS*Y_W-1:0]   gy_q, gy_d, py_q, py_d;
    logic                        ready_q, ready_d;

    logic [TILE_W-1:0] tile;
    logic              is_wall, is_cur, is_prv, snap;
    logic [X_W:0]      dx, dxw;
    logic [Y_W:0]      dy;
    logic [SW-1:0]     sum;
    logic [CELL_W-1:0] code;
    logic [BW-1:0]     bidx;
    logic [TB-1:0]     tidx;

    // classify the current cell (x_q, row_q) against the frame snapshot
    always_comb begin
        tidx = TB'((MAP_W - 1 - int'(x_q)) * TILE_W);
        bidx = BW'((MAP_W - 1 - int'(x_q)) * CELL_W);
        tile = word_q[tidx +: TILE_W];
        is_wall = tile == TILE_W'(WALL_CODE);
        is_cur = 1'b0;
        is_prv = 1'b0;
        for (int g = 0; g < NUM_GHOSTS; g++) begin
            is_cur = is_cur | ((gx_q[g*X_W +: X_W] == x_q) && (gy_q[g*Y_W +: Y_W] == row_q));
            is_prv = is_prv | ((px_q[g*X_W +: X_W] == x_q) && (py_q[g*Y_W +: Y_W] == row_q));
        end
        dx = x_q >= tx_q ? {1'b0, x_q - tx_q} : {1'b0, tx_q - x_q};
        dy = row_q >= ty_q ? {1'b0, row_q - ty_q} : {1'b0, ty_q - row_q};
`ifdef GHOST_MAP_WRAP_EN
        dxw = (dx < W_X && (W_X - dx) < dx) ? W_X - dx : dx;
`else
        dxw = dx;
`endif
        sum = SW'(dxw) + SW'(dy);
        code = is_wall ? C_WALL :
               is_cur  ? C_CUR  :
               is_prv  ? C_PRV  :
               (CW2'(sum) > CW2'(C_SAT)) ? C_SAT : CELL_W'(sum);
    end

    // frame sequencer: fetch row, wait for RAM, fill row buffer, write, repeat
    always_comb begin
        state_d = state_q;
        row_d = row_q;
        x_d = x_q;
        buf_d = buf_q;
        word_d = word_q;
        tx_d = tx_q;
        ty_d = ty_q;
        gx_d = gx_q;
        gy_d = gy_q;
        px_d = px_q;
        py_d = py_q;
        ready_d = ready_q;
        snap = (state_q == S_IDLE && start) || (state_q == S_DONE && continuous);
        case (state_q)
            S_IDLE:  state_d = start ? S_FETCH : S_IDLE;
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                state_d = S_CELL;
                x_d = '0;
                word_d = map_word;
            end
            S_CELL: begin
                buf_d[bidx +: CELL_W] = code;
                x_d = x_q + X_W'(1);
                state_d = x_q == X_LAST ? S_WRITE : S_CELL;
            end
            S_WRITE: begin
                state_d = row_q == Y_LAST ? S_DONE : S_FETCH;
                row_d = row_q == Y_LAST ? row_q : row_q + Y_W'(1);
            end
            S_DONE: begin
                ready_d = 1'b1;
                state_d = continuous ? S_FETCH : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (snap) begin
            row_d = '0;
            tx_d = target_x;
            ty_d = target_y;
            gx_d = ghost_x;
            gy_d = ghost_y;
            px_d = prev_ghost_x;
            py_d = prev_ghost_y;
        end
    end

    // state registers with synchronous reset
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= S_IDLE;
            row_q <= '0;
            x_q <= '0;
            buf_q <= '0;
            word_q <= '0;
            tx_q <= '0;
            ty_q <= '0;
            gx_q <= '0;
            gy_q <= '0;
            px_q <= '0;
            py_q <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q <= row_d;
            x_q <= x_d;
            buf_q <= buf_d;
            word_q <= word_d;
            tx_q <= tx_d;
            ty_q <= ty_d;
            gx_q <= gx_d;
            gy_q <= gy_d;
            px_q <= px_d;
            py_q <= py_d;
            ready_q <= ready_d;
        end
    end

    assign map_rdaddr = row_q;
    assign dist_wraddr = row_q;
    assign dist_wrdata = buf_q;
    assign dist_wren = state_q == S_WRITE;
    assign busy = state_q != S_IDLE;
    assign done = state_q == S_DONE;
    assign ready = ready_q;
endmodule

// File: tb/tb_ghost_dist_map_gen.sv
// tb_ghost_dist_map_gen: directed bench with a cell-level reference model for ghost_dist_map_gen
module tb_ghost_dist_map_gen;
    localparam int MAP_W = 40;
    localparam int MAP_H = 30;
    localparam int X_W = 6;
    localparam int Y_W = 5;
    localparam int NG = 2;
    localparam int CW = 8;
    localparam int TW = 4;
    localparam int WALL = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, continuous, start4;
    logic [X_W-1:0] target_x, t4x;
    logic [Y_W-1:0] target_y, t4y;
    logic [NG*X_W-1:0] ghost_x, prev_ghost_x;
    logic [NG*Y_W-1:0] ghost_y, prev_ghost_y;
    logic [Y_W-1:0] map_rdaddr, dist_wraddr;
    logic [MAP_W*TW-1:0] map_word;
    logic [MAP_W*CW-1:0] dist_wrdata;
    logic dist_wren, busy, done, ready;
    logic [3*X_W-1:0] g4x, p4x;
    logic [3*Y_W-1:0] g4y, p4y;
    logic [Y_W-1:0] rd4, wa4;
    logic [MAP_W*TW-1:0] mw4;
    logic [MAP_W*4-1:0] wd4;
    logic we4, busy4, done4, ready4;

    ghost_dist_map_gen dut (
        .CLOCK_50(clk), .reset(reset), .start(start), .continuous(continuous),
        .target_x(target_x), .target_y(target_y),
        .ghost_x(ghost_x), .ghost_y(ghost_y),
        .prev_ghost_x(prev_ghost_x), .prev_ghost_y(prev_ghost_y),
        .map_rdaddr(map_rdaddr), .map_word(map_word),
        .dist_wraddr(dist_wraddr), .dist_wrdata(dist_wrdata), .dist_wren(dist_wren),
        .busy(busy), .done(done), .ready(ready)
    );

    ghost_dist_map_gen #(.CELL_W(4), .NUM_GHOSTS(3)) dut4 (
        .CLOCK_50(clk), .reset(reset), .start(start4), .continuous(1'b0),
        .target_x(t4x), .target_y(t4y),
        .ghost_x(g4x), .ghost_y(g4y),
        .prev_ghost_x(p4x), .prev_ghost_y(p4y),
        .map_rdaddr(rd4), .map_word(mw4),
        .dist_wraddr(wa4), .dist_wrdata(wd4), .dist_wren(we4),
        .busy(busy4), .done(done4), .ready(ready4)
    );

    logic [TW-1:0] mem [MAP_H][MAP_W];
    logic [MAP_W*CW-1:0] dmem [MAP_H];
    logic [MAP_W*4-1:0] dmem4 [MAP_H];

    function automatic logic [MAP_W*TW-1:0] pack_map(int r);
        logic [MAP_W*TW-1:0] w = '0;
        for (int x = 0; x < MAP_W; x++) w = (w << TW) | (MAP_W*TW)'(mem[r][x]);
        return w;
    endfunction

    // source map RAM with one cycle read latency, and distance-map capture
    always @(posedge clk) begin
        map_word <= pack_map(int'(map_rdaddr));
        mw4 <= pack_map(int'(rd4));
        if (dist_wren) dmem[dist_wraddr] <= dist_wrdata;
        if (we4) dmem4[wa4] <= wd4;
    end

    int checks = 0, errors = 0, exp_row = 0, wren_cnt = 0;
    int s_tx, s_ty;
    int s_gx[NG], s_gy[NG], s_px[NG], s_py[NG];

    task automatic chk(string name, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic snap();
        s_tx = int'(target_x);
        s_ty = int'(target_y);
        for (int g = 0; g < NG; g++) begin
            s_gx[g] = int'(X_W'(ghost_x >> (g*X_W)));
            s_gy[g] = int'(Y_W'(ghost_y >> (g*Y_W)));
            s_px[g] = int'(X_W'(prev_ghost_x >> (g*X_W)));
            s_py[g] = int'(Y_W'(prev_ghost_y >> (g*Y_W)));
        end
    endtask

    function automatic int mcell(int x, int y);
        int adx, ady, d;
        if (int'(mem[y][x]) == WALL) return 255;
        for (int g = 0; g < NG; g++) if (s_gx[g] == x && s_gy[g] == y) return 254;
        for (int g = 0; g < NG; g++) if (s_px[g] == x && s_py[g] == y) return 253;
        adx = x > s_tx ? x - s_tx : s_tx - x;
        ady = y > s_ty ? y - s_ty : s_ty - y;
`ifdef GHOST_MAP_WRAP_EN
        if (MAP_W - adx < adx) adx = MAP_W - adx;
`endif
        d = adx + ady;
        return d > 252 ? 252 : d;
    endfunction

    function automatic logic [MAP_W*CW-1:0] mrow(int y);
        logic [MAP_W*CW-1:0] w = '0;
        for (int x = 0; x < MAP_W; x++) w = (w << CW) | (MAP_W*CW)'(mcell(x, y));
        return w;
    endfunction

    function automatic int dcell(int x, int y);
        return int'(CW'(dmem[y] >> ((MAP_W-1-x)*CW)));
    endfunction

    function automatic int dcell4(int x, int y);
        return int'(4'(dmem4[y] >> ((MAP_W-1-x)*4)));
    endfunction

    // compare every row write of the main instance against the model
    always @(negedge clk) begin
        if (reset) exp_row = 0;
        else begin
            if (!busy && start) begin
                snap();
                exp_row = 0;
            end
            if (dist_wren) begin
                checks++;
                if (exp_row >= MAP_H || int'(dist_wraddr) != exp_row || dist_wrdata !== mrow(exp_row)) begin
                    errors++;
                    $display("FAIL row_write: addr %0d data %h expected addr %0d", dist_wraddr, dist_wrdata, exp_row);
                end
                exp_row++;
                wren_cnt++;
            end
            if (done) begin
                chk("rows_per_frame", exp_row, MAP_H);
                if (continuous) begin
                    snap();
                    exp_row = 0;
                end
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 3000);
        if (!done) chk("done_timeout", 0, 1);
    endtask

    int cyc;

    initial begin
        reset = 1'b1; start = 1'b0; continuous = 1'b0; start4 = 1'b0;
        target_x = 6'd20; target_y = 5'd20;
        ghost_x = {6'd23, 6'd16}; ghost_y = {5'd13, 5'd13};
        prev_ghost_x = {6'd23, 6'd16}; prev_ghost_y = {5'd12, 5'd12};
        t4x = '0; t4y = '0;
        g4x = {6'd7, 6'd6, 6'd5}; g4y = {5'd7, 5'd6, 5'd5};
        p4x = {6'd12, 6'd11, 6'd10}; p4y = {5'd12, 5'd11, 5'd10};
        for (int y = 0; y < MAP_H; y++) for (int x = 0; x < MAP_W; x++) mem[y][x] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_map_rdaddr", int'(map_rdaddr), 0);
        chk("rst_dist_wraddr", int'(dist_wraddr), 0);
        chk("rst_dist_wrdata_zero", int'(dist_wrdata == '0), 1);
        chk("rst_dist_wren", int'(dist_wren), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ready", int'(ready), 0);
        reset = 1'b0;
        @(posedge clk);
        #1 chk("idle_busy", int'(busy), 0);

        // frame A: open map, mid-frame target change and stray start
        wren_cnt = 0;
        pulse_start();
        chk("start_latency_busy", int'(busy), 1);
        fork
            begin
                repeat (100) @(posedge clk);
                #1 target_x = 6'd0;
                repeat (400) @(posedge clk);
                #1 start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
        join_none
        wait_done(cyc);
        chk("frameA_cycles", cyc, 1291);
        chk("frameA_wren_count", wren_cnt, 30);
        chk("A_cur_ghost_16_13", dcell(16, 13), 254);
        chk("A_prev_ghost_23_12", dcell(23, 12), 253);
        chk("A_cell_0_0", dcell(0, 0), 40);
        chk("A_cell_0_29_snapshot", dcell(0, 29), 29);
        chk("A_cell_target", dcell(20, 20), 0);
        chk("A_cell_2_20", dcell(2, 20), 18);
        chk("A_cell_38_20", dcell(38, 20), 18);
        @(posedge clk);
        #1;
        chk("A_ready_set", int'(ready), 1);
        chk("A_busy_clear", int'(busy), 0);
        repeat (60) @(posedge clk);
        #1;
        chk("no_extra_frame", int'(busy), 0);
        chk("ready_sticky", int'(ready), 1);

        // frames B and C back to back in continuous mode
        mem[5][7] = 4'(WALL);
        target_x = 6'd20; target_y = 5'd20;
        ghost_x = {6'd23, 6'd7}; ghost_y = {5'd13, 5'd5};
        continuous = 1'b1;
        pulse_start();
        fork
            begin
                repeat (200) @(posedge clk);
                #1 target_x = 6'd0;
            end
        join_none
        wait_done(cyc);
        chk("frameB_cycles", cyc, 1291);
        chk("B_wall_over_ghost", dcell(7, 5), 255);
        chk("B_cell_0_29_snapshot", dcell(0, 29), 29);
        @(posedge clk);
        #1 continuous = 1'b0;
        chk("C_fetch_after_done", int'(busy), 1);
        chk("C_no_done", int'(done), 0);
        wait_done(cyc);
        chk("frameC_cycles", cyc, 1291);
`ifdef GHOST_MAP_WRAP_EN
        chk("C_cell_38_20_wrap", dcell(38, 20), 2);
`else
        chk("C_cell_38_20", dcell(38, 20), 38);
`endif
        chk("C_cell_2_20", dcell(2, 20), 2);
        chk("C_wall", dcell(7, 5), 255);
        repeat (5) @(posedge clk);
        #1 chk("C_idle", int'(busy), 0);

        // frame D interrupted by reset after row 10, then frame E
        target_x = 6'd5; target_y = 5'd7;
        pulse_start();
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(dist_wren && dist_wraddr == 5'd10) && cyc < 1000);
        chk("D_row10_reached", int'(dist_wren && dist_wraddr == 5'd10), 1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_wren", int'(dist_wren), 0);
        chk("rst_mid_ready", int'(ready), 0);
        chk("rst_mid_done", int'(done), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        target_x = 6'd33; target_y = 5'd2;
        wren_cnt = 0;
        pulse_start();
        wait_done(cyc);
        chk("frameE_cycles", cyc, 1291);
        chk("frameE_wren_count", wren_cnt, 30);
        chk("E_cell_0_0", dcell(0, 0), 35);

        // 4-bit cells, three ghosts, target (0,0)
        @(posedge clk);
        #1 start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done4 && cyc < 3000);
        chk("c4_done_seen", int'(done4), 1);
        chk("c4_cycles", cyc, 1291);
        chk("c4_saturated_39_29", dcell4(39, 29), 12);
        chk("c4_wall", dcell4(7, 5), 15);
        chk("c4_ghost2", dcell4(7, 7), 14);
        chk("c4_ghost0", dcell4(5, 5), 14);
        chk("c4_prev2", dcell4(12, 12), 13);
        chk("c4_prev0", dcell4(10, 10), 13);
        chk("c4_cell_1_1", dcell4(1, 1), 2);
        chk("c4_sat_edge_10_2", dcell4(10, 2), 12);
        chk("c4_below_sat_9_2", dcell4(9, 2), 11);
        @(posedge clk);
        #1 chk("c4_ready", int'(ready4), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
